// File: rtl/sar_cmp_sequencer.sv
// SAR conversion sequencer: sample, then per-bit settle/strobe MSB first, result via valid/ready.
// Define CMP_SYNC_EN to add a 2-flop comparator synchronizer (COMPARE stretches to 3 cycles).
//
// state   | meaning
// IDLE    | waiting for start
// SAMPLE  | sample switch closed for SAMPLE_CYC cycles
// SETTLE  | trial code settling on the DAC for SETTLE_CYC cycles
// COMPARE | comparator strobed; decision taken on the closing edge
// DONE    | result held with valid until the consumer takes it
module sar_cmp_sequencer #(
    parameter int NBITS      = 8,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_o,
    output logic             cmp_en_o,
    output logic [NBITS-1:0] dac_code_o,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             valid,
    input  logic             ready
);

`ifdef CMP_SYNC_EN
    localparam int CMP_CYC = 3;
`else
    localparam int CMP_CYC = 1;
`endif

    localparam int CNT_MAX0 = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int CNT_MAX  = (CNT_MAX0 > CMP_CYC) ? CNT_MAX0 : CMP_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LD_SAMPLE = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CMP    = CNT_W'(CMP_CYC - 1);
    localparam logic [NBITS-1:0] MSB       = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        SETTLE  = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [NBITS-1:0] r_mask;
    logic             w_cmp;
    logic [NBITS-1:0] w_kept;

`ifdef CMP_SYNC_EN
    logic r_cmp_s1;
    logic r_cmp_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_s1 <= 1'b0;
            r_cmp_s2 <= 1'b0;
        end else begin
            r_cmp_s1 <= cmp_in;
            r_cmp_s2 <= r_cmp_s1;
        end
    end

    assign w_cmp = r_cmp_s2;
`else
    assign w_cmp = cmp_in;
`endif

    // Trial bit survives only if the input sits at or above the trial level.
    assign w_kept = w_cmp ? dac_code_o : (dac_code_o & ~r_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mask     <= '0;
            sample_o   <= 1'b0;
            cmp_en_o   <= 1'b0;
            dac_code_o <= '0;
            busy       <= 1'b0;
            result     <= '0;
            valid      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SAMPLE;
                        r_cnt    <= LD_SAMPLE;
                        sample_o <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (r_cnt == '0) begin
                        r_state    <= SETTLE;
                        r_cnt      <= LD_SETTLE;
                        sample_o   <= 1'b0;
                        dac_code_o <= MSB;
                        r_mask     <= MSB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state  <= COMPARE;
                        r_cnt    <= LD_CMP;
                        cmp_en_o <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                COMPARE: begin
                    if (r_cnt == '0) begin
                        cmp_en_o <= 1'b0;
                        if (r_mask[0]) begin
                            r_state    <= DONE;
                            dac_code_o <= w_kept;
                            result     <= w_kept;
                            valid      <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            r_state    <= SETTLE;
                            r_cnt      <= LD_SETTLE;
                            dac_code_o <= w_kept | (r_mask >> 1);
                            r_mask     <= r_mask >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (ready) begin
                        r_state <= IDLE;
                        valid   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
